// File: rtl/fixed_to_float_conv_if.sv
// rtl/fixed_to_float_conv_if.sv - operand/result handshake bundle for fixed_to_float_conv
interface fixed_to_float_conv_if #(
  parameter int IN_WIDTH    = 32,
  parameter int EXP_WIDTH   = 8,
  parameter int FLOAT_EXP_W = 8,
  parameter int FLOAT_MAN_W = 23
);
  logic [IN_WIDTH-1:0]                  fixed;
  logic [EXP_WIDTH-1:0]                 exp_in;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [FLOAT_EXP_W+FLOAT_MAN_W:0]     float_out;
  logic                                 out_valid;
  logic                                 out_ready;

  modport master (
    output fixed, exp_in, in_valid, out_ready,
    input  in_ready, float_out, out_valid
  );

  modport slave (
    input  fixed, exp_in, in_valid, out_ready,
    output in_ready, float_out, out_valid
  );
endinterface

// File: rtl/fixed_to_float_conv.sv
// rtl/fixed_to_float_conv.sv - iterative scaled fixed-point to float converter, RNE, saturating; FIXCONV_FLAGS_EN adds flags[2:0]
module fixed_to_float_conv #(
  parameter int IN_WIDTH    = 32,
  parameter int EXP_WIDTH   = 8,
  parameter int FLOAT_EXP_W = 8,
  parameter int FLOAT_MAN_W = 23
) (
  input  logic clk,
  input  logic rst_n,
`ifdef FIXCONV_FLAGS_EN
  output logic [2:0] flags,
`endif
  fixed_to_float_conv_if.slave bus
);

  localparam int SW   = $clog2(IN_WIDTH) + 1;
  localparam int M1   = (EXP_WIDTH > SW) ? EXP_WIDTH : SW;
  localparam int EW   = ((M1 > FLOAT_EXP_W) ? M1 : FLOAT_EXP_W) + 2;
  localparam int BIAS = (1 << (FLOAT_EXP_W - 1)) - 1;
  localparam int EMAX = (1 << FLOAT_EXP_W) - 1;
  localparam int FW   = 1 + FLOAT_EXP_W + FLOAT_MAN_W;
  localparam int XW   = IN_WIDTH - 1 + FLOAT_MAN_W + 2;

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  state_t               state, state_nxt;
  logic [IN_WIDTH-1:0]  mag_q, abs_val;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [SW-1:0]        s_q;
  logic                 sign_q, zero_q;
  logic [FW-1:0]        float_q;

  logic [XW-1:0]          ext;
  logic [FLOAT_MAN_W-1:0] frac;
  logic [FLOAT_MAN_W:0]   frac_r;
  logic                   guard, sticky, rnd_inc;
  logic [EW-1:0]          e_base, e_rnd;
  logic                   ovf, ufl;
  logic [FW-1:0]          result;
  logic [2:0]             flags_nxt;

  // Two's-complement magnitude; the most negative value maps onto 2^(IN_WIDTH-1) naturally.
  always_comb begin
    abs_val = mag_q;
    if (mag_q[IN_WIDTH-1]) abs_val = ~mag_q + IN_WIDTH'(1);
  end

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ABS;
      end
      ABS:   state_nxt = (abs_val == '0) ? ROUND : NORM;
      NORM:  if (mag_q[IN_WIDTH-1]) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fraction extraction, round-to-nearest-even and exponent range handling.
  always_comb begin
    ext     = {mag_q[IN_WIDTH-2:0], {(FLOAT_MAN_W+2){1'b0}}};
    frac    = ext[XW-1 -: FLOAT_MAN_W];
    guard   = ext[XW-1-FLOAT_MAN_W];
    sticky  = |ext[XW-2-FLOAT_MAN_W:0];
    rnd_inc = guard & (sticky | frac[0]);
    frac_r  = {1'b0, frac} + {{FLOAT_MAN_W{1'b0}}, rnd_inc};
    e_base  = EW'(IN_WIDTH - 1) - EW'(s_q)
            + {{(EW-EXP_WIDTH){exp_q[EXP_WIDTH-1]}}, exp_q} + EW'(BIAS);
    e_rnd   = e_base + EW'(frac_r[FLOAT_MAN_W]);
    ovf     = !e_rnd[EW-1] && (e_rnd >= EW'(EMAX));
    ufl     = e_rnd[EW-1] || (e_rnd == '0);
    result  = {sign_q, e_rnd[FLOAT_EXP_W-1:0], frac_r[FLOAT_MAN_W-1:0]};
    if (zero_q)   result = '0;
    else if (ovf) result = {sign_q, {FLOAT_EXP_W{1'b1}}, {FLOAT_MAN_W{1'b0}}};
    else if (ufl) result = {sign_q, {(FW-1){1'b0}}};
    flags_nxt = zero_q ? 3'b000 : {ovf, ufl, guard | sticky | ovf | ufl};
  end

  // Operand capture, magnitude, normalisation shifts and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q   <= '0;
      exp_q   <= '0;
      s_q     <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      float_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mag_q  <= bus.fixed;
          exp_q  <= bus.exp_in;
          s_q    <= '0;
          zero_q <= 1'b0;
        end
        ABS: begin
          sign_q <= mag_q[IN_WIDTH-1];
          mag_q  <= abs_val;
          zero_q <= (abs_val == '0);
        end
        NORM: if (!mag_q[IN_WIDTH-1]) begin
          mag_q <= mag_q << 1;
          s_q   <= s_q + SW'(1);
        end
        ROUND:   float_q <= result;
        default: ;
      endcase
    end
  end

  assign bus.float_out = float_q;

`ifdef FIXCONV_FLAGS_EN
  logic [2:0] flags_q;

  // Status flags travel with the result word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              flags_q <= 3'b000;
    else if (state == ROUND) flags_q <= flags_nxt;
  end

  assign flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^flags_nxt;
`endif

endmodule

// File: tb/tb_fixed_to_float_conv.sv
// tb/tb_fixed_to_float_conv.sv - directed self-checking bench for fixed_to_float_conv
module tb_fixed_to_float_conv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] res;
  logic [31:0] held;
  int lat;

  always #5 clk = ~clk;

  fixed_to_float_conv_if #(.IN_WIDTH(32), .EXP_WIDTH(8), .FLOAT_EXP_W(8), .FLOAT_MAN_W(23)) bus ();
  fixed_to_float_conv_if #(.IN_WIDTH(8), .EXP_WIDTH(8), .FLOAT_EXP_W(5), .FLOAT_MAN_W(10)) sbus ();

`ifdef FIXCONV_FLAGS_EN
  logic [2:0] flags, flags_s, last_flags;
`endif

  fixed_to_float_conv #(.IN_WIDTH(32), .EXP_WIDTH(8), .FLOAT_EXP_W(8), .FLOAT_MAN_W(23)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FIXCONV_FLAGS_EN
    .flags(flags),
`endif
    .bus(bus)
  );

  fixed_to_float_conv #(.IN_WIDTH(8), .EXP_WIDTH(8), .FLOAT_EXP_W(5), .FLOAT_MAN_W(10)) dut_s (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FIXCONV_FLAGS_EN
    .flags(flags_s),
`endif
    .bus(sbus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the converter back in IDLE (out_ready high).
  task automatic convert(input logic [31:0] f, input logic [7:0] e,
                         output logic [31:0] r, output int n);
    int w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", bus.in_ready, 1);
    bus.fixed = f;
    bus.exp_in = e;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", bus.out_valid, 1);
    r = bus.float_out;
`ifdef FIXCONV_FLAGS_EN
    last_flags = flags;
`endif
    @(negedge clk);
  endtask

  initial begin
    bus.fixed = '0; bus.exp_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    sbus.fixed = '0; sbus.exp_in = '0; sbus.in_valid = 1'b0; sbus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_float_out", bus.float_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(32'd1, 8'd0, res, lat);
    check("one", res, 32'h3f800000);
    check("one_lat", lat, 35);
    convert(32'd1, 8'd1, res, lat);
    check("two", res, 32'h40000000);
    convert(32'd13, 8'hff, res, lat);
    check("13_half", res, 32'h40d00000);
    convert(32'hffffffff, 8'd0, res, lat);
    check("minus_one", res, 32'hbf800000);
    convert(32'h80000000, 8'd0, res, lat);
    check("most_neg", res, 32'hcf000000);
    check("most_neg_lat", lat, 4);
    convert(32'h01000001, 8'd0, res, lat);
    check("rne_tie_even", res, 32'h4b800000);
`ifdef FIXCONV_FLAGS_EN
    check("flags_tie", last_flags, 3'b001);
`endif
    convert(32'h01000003, 8'd0, res, lat);
    check("rne_tie_up", res, 32'h4b800002);
    convert(32'h01ffffff, 8'd0, res, lat);
    check("rne_carry", res, 32'h4c000000);
    convert(32'd1, 8'd127, res, lat);
    check("max_exp", res, 32'h7f000000);
`ifdef FIXCONV_FLAGS_EN
    check("flags_exact", last_flags, 3'b000);
`endif
    convert(32'd1, 8'h80, res, lat);
    check("underflow", res, 32'h00000000);
`ifdef FIXCONV_FLAGS_EN
    check("flags_uf", last_flags, 3'b011);
`endif
    convert(32'd3, 8'd127, res, lat);
    check("overflow", res, 32'h7f800000);
`ifdef FIXCONV_FLAGS_EN
    check("flags_of", last_flags, 3'b101);
`endif
    convert(32'd0, 8'd5, res, lat);
    check("zero", res, 32'h00000000);
    check("zero_lat", lat, 3);

    // Back-pressure in DONE with stray in_valid pulses.
    bus.out_ready = 1'b0;
    bus.fixed = 32'd5; bus.exp_in = 8'd0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    held = bus.float_out;
    check("hold_value", held, 32'h40a00000);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.fixed = 32'd77;
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_float", bus.float_out, held);
      check("hold_busy", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", bus.out_valid, 0);
    check("release_ready", bus.in_ready, 1);
    check("release_retain", bus.float_out, 32'h40a00000);
    convert(32'd7, 8'd0, res, lat);
    check("after_hold", res, 32'h40e00000);

    // Reset during normalisation.
    bus.fixed = 32'd1; bus.exp_in = 8'd0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_float", bus.float_out, 0);
`ifdef FIXCONV_FLAGS_EN
    check("midrst_flags", flags, 3'b000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    convert(32'd2, 8'd0, res, lat);
    check("post_rst", res, 32'h40000000);
    check("post_rst_lat", lat, 34);

    // Narrow configuration.
    sbus.fixed = 8'h7f; sbus.exp_in = 8'd0; sbus.in_valid = 1'b1;
    @(negedge clk);
    sbus.in_valid = 1'b0;
    lat = 1;
    while (!sbus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("narrow_valid", sbus.out_valid, 1);
    check("narrow_value", sbus.float_out, 16'h57f0);
    check("narrow_lat", lat, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
